// File: rtl/quad_add_sub_top.sv
// quad_add_sub_top: two-stage pipeline computing (a+b) + (c+d) or (a+b) - (c+d), sign-extended.
// Define CAL_ABS_EN to make the subtract path return the zero-extended magnitude instead.
module quad_add_sub_top #(
    parameter int DATA_W = 2,
    parameter int OUT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_add_a,
    input  logic [DATA_W-1:0] in_add_b,
    input  logic [DATA_W-1:0] in_add_c,
    input  logic [DATA_W-1:0] in_add_d,
    input  logic              in_add_sub_sel,
    output logic              out_valid,
    output logic [OUT_W-1:0]  final_cal_out
);
    if (OUT_W < DATA_W + 3) begin : g_width_check
        $error("quad_add_sub_top: OUT_W must be at least DATA_W+3");
    end

    logic [DATA_W:0]  sum_ab, sum_cd;
    logic             sel1, v1;
    logic [OUT_W-1:0] ext_ab, ext_cd, add_res, sub_res, res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_ab <= '0;
            sum_cd <= '0;
            sel1   <= 1'b0;
            v1     <= 1'b0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                sum_ab <= {1'b0, in_add_a} + {1'b0, in_add_b};
                sum_cd <= {1'b0, in_add_c} + {1'b0, in_add_d};
                sel1   <= in_add_sub_sel;
            end
        end
    end

    // Two guard bits above the partial sums keep the difference exact in two's complement.
    assign ext_ab  = OUT_W'(sum_ab);
    assign ext_cd  = OUT_W'(sum_cd);
    assign add_res = ext_ab + ext_cd;
    assign sub_res = ext_ab - ext_cd;

    always_comb begin
`ifdef CAL_ABS_EN
        res = sel1 ? (sub_res[OUT_W-1] ? -sub_res : sub_res) : add_res;
`else
        res = sel1 ? sub_res : add_res;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            final_cal_out <= '0;
        end else begin
            out_valid <= v1;
            if (v1) final_cal_out <= res;
        end
    end
endmodule

// File: tb/tb_quad_add_sub_top.sv
// tb_quad_add_sub_top: directed and exhaustive streaming checks for quad_add_sub_top.
// Honours CAL_ABS_EN so the same bench covers both builds.
module tb_quad_add_sub_top;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] in_add_a = '0, in_add_b = '0, in_add_c = '0, in_add_d = '0;
    logic       in_add_sub_sel = 1'b0;
    logic       out_valid;
    logic [7:0] final_cal_out;
    int         checks = 0;
    int         failures = 0;

    quad_add_sub_top #(.DATA_W(2), .OUT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_add_a(in_add_a), .in_add_b(in_add_b), .in_add_c(in_add_c), .in_add_d(in_add_d),
        .in_add_sub_sel(in_add_sub_sel), .out_valid(out_valid), .final_cal_out(final_cal_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int v, input int a, input int b, input int c, input int d, input int s);
        in_valid       = v[0];
        in_add_a       = a[1:0];
        in_add_b       = b[1:0];
        in_add_c       = c[1:0];
        in_add_d       = d[1:0];
        in_add_sub_sel = s[0];
    endtask

    function automatic logic [7:0] model(input int a, input int b, input int c, input int d, input int s);
        int r;
        r = s[0] ? (a + b) - (c + d) : (a + b) + (c + d);
`ifdef CAL_ABS_EN
        if (r < 0) r = -r;
`endif
        return r[7:0];
    endfunction

    task automatic run_one(input string tag, input int a, input int b, input int c, input int d,
                           input int s, input logic [7:0] exp);
        drive(1, a, b, c, d, s);
        step();
        drive(0, 0, 0, 0, 0, 0);
        check({tag, "_lat1_valid"}, 32'(out_valid), 32'd0);
        step();
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, 32'(final_cal_out), 32'(exp));
        step();
        check({tag, "_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_hold"}, 32'(final_cal_out), 32'(exp));
    endtask

    logic [7:0] neg_exp;

    initial begin
`ifdef CAL_ABS_EN
        neg_exp = 8'h06;
`else
        neg_exp = 8'hFA;
`endif
        #2;
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_data", 32'(final_cal_out), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check("idle_valid", 32'(out_valid), 32'd0);

        run_one("add_max", 3, 3, 3, 3, 0, 8'h0C);
        run_one("sub_pos", 3, 2, 1, 0, 1, 8'h04);
        run_one("sub_neg", 0, 0, 3, 3, 1, neg_exp);
        run_one("sub_zero", 2, 1, 1, 2, 1, 8'h00);

        // Bubble: valid, gap, valid
        drive(1, 3, 3, 3, 3, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        step();
        drive(1, 3, 2, 1, 0, 1);
        check("bub_v1", 32'(out_valid), 32'd1);
        check("bub_d1", 32'(final_cal_out), 32'h0C);
        step();
        drive(0, 0, 0, 0, 0, 0);
        check("bub_v0", 32'(out_valid), 32'd0);
        check("bub_hold", 32'(final_cal_out), 32'h0C);
        step();
        check("bub_v2", 32'(out_valid), 32'd1);
        check("bub_d2", 32'(final_cal_out), 32'h04);
        step();

        // Exhaustive back-to-back sweep
        for (int i = 0; i <= 512; i++) begin
            int p;
            if (i < 512) drive(1, (i >> 1) & 3, (i >> 3) & 3, (i >> 5) & 3, (i >> 7) & 3, i & 1);
            else drive(0, 0, 0, 0, 0, 0);
            step();
            if (i >= 1) begin
                p = i - 1;
                check($sformatf("sweep_%0d", p), {23'd0, out_valid, final_cal_out},
                      {23'd0, 1'b1, model((p >> 1) & 3, (p >> 3) & 3, (p >> 5) & 3, (p >> 7) & 3, p & 1)});
            end
        end
        step();
        check("sweep_end_valid", 32'(out_valid), 32'd0);

        // Asynchronous reset in the middle of a stream
        drive(1, 3, 3, 3, 3, 0);
        step();
        step();
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_data", 32'(final_cal_out), 32'd0);
        step();
        check("in_rst_valid", 32'(out_valid), 32'd0);
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        step();
        check("post_rst_idle", 32'(out_valid), 32'd0);
        check("post_rst_data", 32'(final_cal_out), 32'd0);
        run_one("post_rst", 1, 2, 3, 0, 1, 8'h00);
        run_one("post_rst_add", 1, 0, 2, 0, 0, 8'h03);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/quad_add_sub_top.md
Name: quad_add_sub_top

Overview:
- Two-stage pipelined arithmetic block: sums operand pairs (a+b) and (c+d), then adds or subtracts the two partial sums under a select bit.
- Result is a sign-extended two's-complement value on a fixed-width output.
- Sits as the top of a small datapath exercise; the adder and subtractor may be separate submodules instantiated here.

Parameters:
- DATA_W, 2, width of each operand input (unsigned).
- OUT_W, 8, width of final_cal_out. Must satisfy OUT_W >= DATA_W+3; elaboration error otherwise.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and select are sampled on this clk edge when high.
- in_add_a  input  DATA_W  operand a, unsigned.
- in_add_b  input  DATA_W  operand b, unsigned.
- in_add_c  input  DATA_W  operand c, unsigned.
- in_add_d  input  DATA_W  operand d, unsigned.
- in_add_sub_sel  input  1  0 = add partial sums, 1 = subtract (ab - cd).
- out_valid  output  1  final_cal_out carries a new result this cycle.
- final_cal_out  output  OUT_W  result, two's complement.

Behaviour:
- Reset: one clock domain, clk; rst_n is asynchronous and active-low. While rst_n=0, all pipeline registers, out_valid and final_cal_out are 0. Release is synchronous to the next clk edge; no input is sampled on that edge if in_valid=0.
- Stage 1, on a clk edge with in_valid=1:
  - sum_ab = a+b, DATA_W+1 bits, no loss.
  - sum_cd = c+d, DATA_W+1 bits, no loss.
  - sel is registered alongside; v1 is set to 1.
  - With in_valid=0: v1 is set to 0 and the stage-1 data registers hold their values.
- Stage 2, on a clk edge with v1=1:
  - final_cal_out = zero-extend(sum_ab) + zero-extend(sum_cd) when sel=0.
  - final_cal_out = sign-correct (sum_ab - sum_cd), sign-extended to OUT_W, when sel=1.
  - out_valid is set to 1.
  - With v1=0: out_valid is set to 0 and final_cal_out holds its last value.
- Latency: exactly 2 clk cycles from in_valid sample to out_valid.
- Throughput: one result per cycle; back-to-back in_valid is fully supported. Bubbles propagate unchanged.
- Ranges (defaults): add result 0..12 (0x00..0x0C); subtract result -6..+6 (0xFA..0x06).
- Overflow: none possible given the OUT_W constraint.
- Reset mid-operation: in-flight results are discarded; out_valid=0 until fresh input has passed through both stages.
- No X propagation: all registers have a reset value.

Optional Feature:
- Macro: CAL_ABS_EN.
- Defined: when sel=1, final_cal_out is the magnitude |sum_ab - sum_cd|, zero-extended. The output is then always non-negative, e.g. 0 - 6 gives 0x06.
- Undefined: two's-complement signed result as above, e.g. 0 - 6 gives 0xFA.
- Add path is identical in both builds; latency is unchanged.

Test Plan:
- Reset check: assert rst_n=0 mid-stream with in_valid=1 -> out_valid=0 and final_cal_out=0x00 immediately, asynchronously. After release, first out_valid occurs exactly 2 cycles after the first sampled in_valid.
- Add, max operands: a=3, b=3, c=3, d=3, sel=0 -> final_cal_out=0x0C, 2 cycles later.
- Subtract, positive result: a=3, b=2, c=1, d=0, sel=1 -> 0x04.
- Subtract, negative result: a=0, b=0, c=3, d=3, sel=1 -> 0xFA (0x06 with CAL_ABS_EN).
- Exhaustive streaming sweep: drive a 9-bit counter 0..511 with sel=cnt[0], a=cnt[2:1], b=cnt[4:3], c=cnt[6:5], d=cnt[8:7], in_valid=1 every cycle -> every output matches the reference model, 2 cycles delayed, with no gaps.
- Bubble handling: toggle in_valid 1,0,1 -> out_valid follows 1,0,1 delayed by 2 cycles. final_cal_out holds its previous value during the bubble cycle.
